// File: rtl/sif_mp.sv
// Multi-port register storage: one X read/write port plus NW write-only W channels, fixed-priority writes.
// Latency: reads return after RD_LAT cycles; errors, drops and the collision count are registered one cycle after the request.
// Backpressure: none; every strobe is accepted or reported the next cycle.
module sif_mp #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int DEPTH  = 16,
  parameter int NW     = 2,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             xa_wr_s,
  input  logic             xa_rd_s,
  input  logic [AW-1:0]    xa_addr,
  input  logic [DW-1:0]    xa_data_wr,
  output logic [DW-1:0]    xa_data_rd,
  output logic             xa_rd_vld,
  output logic             xa_err,
  input  logic [NW-1:0]    wa_wr_s,
  input  logic [NW*AW-1:0] wa_addr,
  input  logic [NW*DW-1:0] wa_data_wr,
  output logic [NW-1:0]    wa_drop,
  output logic [7:0]       coll_cnt
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic          x_oor;
  logic          x_wr_ok;
  logic          rd_go;
  logic          wr_err;
  logic [DW-1:0] rd_dat;
  logic [AW-1:0] w_addr [NW];
  logic [DW-1:0] w_dat  [NW];
  logic [NW-1:0] w_ok;
  logic [NW-1:0] w_drop;
  logic [3:0]    n_drop;
  logic [8:0]    cnt_sum;

  // Second read stage, only exercised when RD_LAT == 2.
  logic          s1_vld;
  logic          s1_err;
  logic [DW-1:0] s1_dat;

  always_comb begin
    x_oor   = ({1'b0, xa_addr} >= DEPTH_W);
    x_wr_ok = xa_wr_s & ~x_oor;
    rd_go   = xa_rd_s & ~xa_wr_s;
    wr_err  = xa_wr_s & (x_oor | xa_rd_s);
    rd_dat  = x_oor ? '0 : mem[xa_addr[IW-1:0]];
    for (int i = 0; i < NW; i++) begin
      w_addr[i] = wa_addr[i*AW +: AW];
      w_dat[i]  = wa_data_wr[i*DW +: DW];
      w_ok[i]   = wa_wr_s[i] & ({1'b0, w_addr[i]} < DEPTH_W);
    end
    w_drop = '0;
    n_drop = '0;
    // A W channel loses if any valid higher-priority writer targets the same word.
    for (int i = 0; i < NW; i++) begin
      w_drop[i] = w_ok[i] & x_wr_ok & (w_addr[i] == xa_addr);
      for (int j = 0; j < NW; j++) begin
        if (j < i && w_ok[j] && (w_addr[j] == w_addr[i])) begin
          w_drop[i] = w_ok[i];
        end
      end
      n_drop = n_drop + 4'(w_drop[i]);
    end
    cnt_sum = {1'b0, coll_cnt} + 9'(n_drop);
  end

  // Winners are unique per address, so commit order among them does not matter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      if (x_wr_ok) begin
        mem[xa_addr[IW-1:0]] <= xa_data_wr;
      end
      for (int i = 0; i < NW; i++) begin
        if (w_ok[i] && !w_drop[i]) begin
          mem[w_addr[i][IW-1:0]] <= w_dat[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      xa_data_rd <= '0;
      xa_rd_vld  <= 1'b0;
      xa_err     <= 1'b0;
      wa_drop    <= '0;
      coll_cnt   <= '0;
      s1_vld     <= 1'b0;
      s1_err     <= 1'b0;
      s1_dat     <= '0;
    end else begin
      wa_drop  <= w_drop;
      coll_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
      if (RD_LAT == 1) begin
        xa_rd_vld <= rd_go;
        xa_err    <= wr_err | (rd_go & x_oor);
        if (rd_go) begin
          xa_data_rd <= rd_dat;
        end
      end else begin
        s1_vld    <= rd_go;
        s1_err    <= rd_go & x_oor;
        s1_dat    <= rd_dat;
        xa_rd_vld <= s1_vld;
        xa_err    <= wr_err | s1_err;
        if (s1_vld) begin
          xa_data_rd <= s1_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_sif_mp.sv
// Randomized and directed bench for sif_mp; RD_LAT=1 and RD_LAT=2 instances share stimulus.
module tb_sif_mp;
  localparam int DEPTH = 16;
  localparam int MAXC  = 4096;

  typedef struct {
    int          due;
    logic [15:0] dat;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        xa_wr_s = 1'b0, xa_rd_s = 1'b0;
  logic [15:0] xa_addr = '0, xa_data_wr = '0;
  logic [1:0]  wa_wr_s = '0;
  logic [31:0] wa_addr = '0, wa_data_wr = '0;
  logic [15:0] d1, d2;
  logic        v1, v2, e1, e2;
  logic [1:0]  drop1, drop2;
  logic [7:0]  cnt1, cnt2;

  int          edge_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  rd_t         q1[$];
  rd_t         q2[$];
  logic [15:0] hold [2];
  logic        erra0 [MAXC];
  logic        erra1 [MAXC];
  logic [1:0]  drop_arr [MAXC];
  logic [7:0]  cnt_arr [MAXC];
  logic [15:0] ref_mem [DEPTH];
  int          ref_cnt;

  sif_mp #(.AW(16), .DW(16), .DEPTH(DEPTH), .NW(2), .RD_LAT(1)) u1 (
    .clk(clk), .rst_b(rst_b), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr),
    .xa_data_wr(xa_data_wr), .xa_data_rd(d1), .xa_rd_vld(v1), .xa_err(e1),
    .wa_wr_s(wa_wr_s), .wa_addr(wa_addr), .wa_data_wr(wa_data_wr), .wa_drop(drop1), .coll_cnt(cnt1));

  sif_mp #(.AW(16), .DW(16), .DEPTH(DEPTH), .NW(2), .RD_LAT(2)) u2 (
    .clk(clk), .rst_b(rst_b), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr),
    .xa_data_wr(xa_data_wr), .xa_data_rd(d2), .xa_rd_vld(v2), .xa_err(e2),
    .wa_wr_s(wa_wr_s), .wa_addr(wa_addr), .wa_data_wr(wa_data_wr), .wa_drop(drop2), .coll_cnt(cnt2));

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got 0x%0h, want 0x%0h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic pop(input int k);
    if (k == 0) void'(q1.pop_front());
    else        void'(q2.pop_front());
  endtask

  task automatic mon(input int k, input logic vld, input logic [15:0] dat, input logic err);
    int   n;
    rd_t  f;
    bit   have;
    logic e_exp;
    string p;
    n = edge_cnt;
    p = (k == 0) ? "L1" : "L2";
    if (k == 0) begin
      have = q1.size() > 0;
      if (have) f = q1[0];
      e_exp = erra0[n];
    end else begin
      have = q2.size() > 0;
      if (have) f = q2[0];
      e_exp = erra1[n];
    end
    if (!rst_b) begin
      chk({p, " rst_vld"}, {31'd0, vld}, 0);
      chk({p, " rst_err"}, {31'd0, err}, 0);
      chk({p, " rst_data"}, {16'd0, dat}, 0);
    end else begin
      if (vld) begin
        if (have && f.due == n) begin
          chk({p, " rd_data"}, {16'd0, dat}, {16'd0, f.dat});
          hold[k] = f.dat;
          pop(k);
        end else begin
          chk({p, " rd_vld_spurious"}, {31'd0, vld}, 0);
        end
      end else if (have && f.due <= n) begin
        chk({p, " rd_vld_missing"}, {31'd0, vld}, 1);
        pop(k);
      end
      chk({p, " data_hold"}, {16'd0, dat}, {16'd0, hold[k]});
      chk({p, " xa_err"}, {31'd0, err}, {31'd0, e_exp});
    end
  endtask

  always @(negedge clk) begin
    mon(0, v1, d1, e1);
    mon(1, v2, d2, e2);
    if (!rst_b) begin
      chk("rst_drop", {28'd0, drop1, drop2}, 0);
      chk("rst_cnt", {16'd0, cnt1, cnt2}, 0);
    end else begin
      chk("L1 wa_drop", {30'd0, drop1}, {30'd0, drop_arr[edge_cnt]});
      chk("L2 wa_drop", {30'd0, drop2}, {30'd0, drop_arr[edge_cnt]});
      chk("L1 coll_cnt", {24'd0, cnt1}, {24'd0, cnt_arr[edge_cnt]});
      chk("L2 coll_cnt", {24'd0, cnt2}, {24'd0, cnt_arr[edge_cnt]});
    end
  end

  task automatic idle_inputs();
    xa_wr_s = 0; xa_rd_s = 0; xa_addr = '0; xa_data_wr = '0;
    wa_wr_s = '0; wa_addr = '0; wa_data_wr = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst_b = 1'b0;
    idle_inputs();
    q1.delete();
    q2.delete();
    hold[0] = '0;
    hold[1] = '0;
    ref_cnt = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = edge_cnt; i < MAXC; i++) begin
      erra0[i] = 0; erra1[i] = 0; drop_arr[i] = '0; cnt_arr[i] = '0;
    end
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
    rst_b = 1'b1;
  endtask

  // Reference: read sees pre-edge storage; writers claim addresses in priority order, later claimants lose.
  task automatic step(input logic xw, input logic xr, input int xa, input logic [15:0] xd,
                      input logic [1:0] ws, input int a0, input int a1,
                      input logic [15:0] wd0, input logic [15:0] wd1);
    int          t;
    logic [15:0] rdat;
    bit          claimed [DEPTH];
    logic [1:0]  drops;
    int          a;
    logic [15:0] d;
    t = edge_cnt;
    xa_wr_s = xw; xa_rd_s = xr; xa_addr = xa[15:0]; xa_data_wr = xd;
    wa_wr_s = ws; wa_addr = {a1[15:0], a0[15:0]}; wa_data_wr = {wd1, wd0};
    if (xw && (xa >= DEPTH || xr)) begin
      erra0[t+1] = 1; erra1[t+1] = 1;
    end
    if (xr && !xw) begin
      rdat = (xa < DEPTH) ? ref_mem[xa] : 16'h0;
      q1.push_back('{due: t + 1, dat: rdat});
      q2.push_back('{due: t + 2, dat: rdat});
      if (xa >= DEPTH) begin
        erra0[t+1] = 1; erra1[t+2] = 1;
      end
    end
    for (int i = 0; i < DEPTH; i++) claimed[i] = 0;
    drops = '0;
    if (xw && xa < DEPTH) begin
      ref_mem[xa] = xd;
      claimed[xa] = 1;
    end
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? a0 : a1;
      d = (i == 0) ? wd0 : wd1;
      if (ws[i] && a < DEPTH) begin
        if (claimed[a]) begin
          drops[i] = 1'b1;
          if (ref_cnt < 255) ref_cnt++;
        end else begin
          claimed[a] = 1;
          ref_mem[a] = d;
        end
      end
    end
    drop_arr[t+1] = drops;
    cnt_arr[t+1]  = 8'(ref_cnt);
    @(posedge clk);
    #2;
  endtask

  task automatic xrd(input int a);
    step(0, 1, a, 16'h0, 2'b00, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic xwr(input int a, input logic [15:0] d);
    step(1, 0, a, d, 2'b00, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic nop();
    step(0, 0, 0, 16'h0, 2'b00, 0, 0, 16'h0, 16'h0);
  endtask

  function automatic int raddr();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 3));
    return int'($urandom_range(0, 18));
  endfunction

  initial begin
    do_reset(3);
    xrd(3);
    nop();
    xwr(5, 16'hA5A5);
    xrd(5);
    nop();
    xrd(5); xrd(6); xrd(5);
    nop(); nop();
    step(1, 0, 7, 16'h3333, 2'b11, 7, 7, 16'h1111, 16'h2222);
    xrd(7);
    step(0, 0, 0, 16'h0, 2'b11, 1, 2, 16'h1111, 16'h2222);
    xrd(1); xrd(2);
    xwr(4, 16'h00AA);
    step(0, 1, 4, 16'h0, 2'b01, 4, 0, 16'h00BB, 16'h0);
    xrd(4);
    xwr(16, 16'hDEAD);
    xrd(16);
    step(1, 1, 3, 16'h0333, 2'b00, 0, 0, 16'h0, 16'h0);
    xrd(3);
    step(0, 0, 0, 16'h0, 2'b11, 20, 20, 16'h4444, 16'h5555);
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0, 16'h0, 2'b11, 9, 9, 16'($urandom), 16'($urandom));
    end
    xrd(9);
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, raddr(), 16'($urandom),
           2'($urandom_range(0, 3)), raddr(), raddr(), 16'($urandom), 16'($urandom));
    end
    xwr(5, 16'h1234);
    xrd(5);
    do_reset(2);
    nop();
    for (int a = 0; a < 18; a++) xrd(a);
    repeat (4) nop();
    chk("L1 rdq_drained", q1.size(), 0);
    chk("L2 rdq_drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sif_mp.md
Name: sif_mp

Overview:
- Parametrised multi-port storage interface; successor to the single X/W port sif block.
- Register-based storage array with one read/write X port and NW write-only W channels.
- Adds fixed-priority write arbitration, same-address collision detection and counting, configurable read latency with a valid strobe, and out-of-range address checking.
- Sits between the X/W stimulus interfaces (or compute engines) and the datapath consuming stored words.

Parameters:
- AW, 16, address width of every port.
- DW, 16, data width of every port.
- DEPTH, 16, number of stored words; legal addresses are 0..DEPTH-1, DEPTH <= 2**AW.
- NW, 2, number of write-only W channels, 1..8.
- RD_LAT, 1, read latency in cycles, 1 or 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_b  input  1  asynchronous active-low reset.
- xa_wr_s  input  1  X write strobe.
- xa_rd_s  input  1  X read strobe.
- xa_addr  input  AW  X address.
- xa_data_wr  input  DW  X write data.
- xa_data_rd  output  DW  X read data.
- xa_rd_vld  output  1  one-cycle pulse; xa_data_rd is valid.
- xa_err  output  1  one-cycle pulse on an illegal X access.
- wa_wr_s  input  NW  per-channel W write strobe.
- wa_addr  input  NW*AW  W addresses; channel i occupies bits [i*AW +: AW].
- wa_data_wr  input  NW*DW  W write data; channel i occupies bits [i*DW +: DW].
- wa_drop  output  NW  one-cycle pulse; channel write was lost to a higher-priority writer.
- coll_cnt  output  8  saturating count of dropped W writes.

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears:
  - all DEPTH words to 0;
  - xa_data_rd=0, xa_rd_vld=0, xa_err=0, wa_drop=0, coll_cnt=0;
  - the read pipeline.
- Reset mid-operation aborts any in-flight read; no xa_rd_vld is produced for it.
- Write priority, fixed: X port highest, then W channel 0, 1, ... NW-1.
  - All accepted writes commit on the same rising edge.
  - Writers to distinct addresses never interfere.
- Same-address collision: only the highest-priority writer commits.
  - Each losing W channel pulses wa_drop[i] the next cycle.
  - coll_cnt increments by the number of losers in that cycle and saturates at 255.
  - An X write never drops.
- Out-of-range address (addr >= DEPTH):
  - W write is silently ignored; no wa_drop, no count.
  - X write is ignored and pulses xa_err next cycle.
  - X read returns 0 with xa_rd_vld and xa_err both pulsed.
- xa_wr_s and xa_rd_s asserted together: write performed, read discarded, xa_err pulses next cycle, no xa_rd_vld.
- Read (xa_rd_s alone, in range) at cycle T:
  - xa_rd_vld=1 and xa_data_rd valid in cycle T+RD_LAT.
  - Data is sampled at cycle T.
  - Reads may issue every cycle, fully pipelined.
- Read-during-write, any port, same address, same cycle: read-first; the read returns the old word.
- xa_data_rd holds the last returned value until the next valid read; it is not cleared when xa_rd_vld drops.
- xa_err, wa_drop and xa_rd_vld are single-cycle pulses, registered, one cycle after the triggering request. Exception: xa_rd_vld for RD_LAT=2 and the out-of-range read error follow the read-latency timing.
- Storage wraps nothing: addresses are never truncated modulo DEPTH.

Test Plan:
- Reset, then X read of addr 3 with RD_LAT=1 -> xa_data_rd=0x0000 and xa_rd_vld=1 one cycle later; xa_err=0.
- X write 0xA5A5 at addr 5, then X read addr 5 -> 0xA5A5 after RD_LAT cycles. Back-to-back reads of addrs 5,6,5 with RD_LAT=2 -> three consecutive vld pulses returning 0xA5A5, 0, 0xA5A5.
- Same cycle: W0 writes 0x1111, W1 writes 0x2222, X writes 0x3333, all to addr 7 -> addr 7 holds 0x3333; wa_drop=2'b11; coll_cnt=2.
- Same cycle: W0 writes 0x1111 to addr 1 and W1 writes 0x2222 to addr 2 -> both stored, wa_drop=0, coll_cnt unchanged.
- X read of addr 4 (holding 0x00AA) while W0 writes 0x00BB to addr 4 -> read returns 0x00AA; a subsequent read returns 0x00BB.
- X write to addr 16 with DEPTH=16 -> xa_err pulses, storage unchanged. 300 forced collisions -> coll_cnt=255. Assert rst_b low with a read in flight -> no xa_rd_vld, all outputs 0.
